tlv493d_poller: RTL and testbench

//  Avalon-MM master that sits directly upstream of I2C_avalon_bridge and drives it autonomously.

---
 rtl/tlv493d_poller_if.sv | 19 +
 rtl/tlv493d_poller.sv | 174 +++++++++++++++++
 tb/tb_tlv493d_poller.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlv493d_poller_if.sv
// Avalon-MM bus between the TLV493D poller (master) and the I2C bridge (slave).
interface tlv493d_poller_if;
  logic [2:0]  avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_write, avm_writedata, avm_read,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_write, avm_writedata, avm_read,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/tlv493d_poller.sv
// Autonomous TLV493D poller: programs the I2C bridge for a 7-byte read, drains its FIFO,
// decodes Bx/By/Bz/temperature and strobes each new sample.
module tlv493d_poller #(
  parameter int unsigned CLOCK_SPEED_HZ = 50_000_000,
  parameter int unsigned POLL_HZ        = 100,
  parameter int unsigned NUM_BYTES      = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [6:0]              slave_addr,
  tlv493d_poller_if.master        avm,
  output logic [11:0]             bx,
  output logic [11:0]             by,
  output logic [11:0]             bz,
  output logic [11:0]             temp,
  output logic [1:0]              frame_cnt,
  output logic                    sample_valid,
  output logic                    stale,
  output logic                    error,
  output logic [15:0]             sample_count
);

  localparam int unsigned PollTicks = CLOCK_SPEED_HZ / POLL_HZ;
  localparam int unsigned CntW      = $clog2(PollTicks + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(PollTicks - 1);

  typedef enum logic [3:0] {
    StIdle, StWrAddr, StWrRw, StWrNb, StWrRo, StWrEna,
    StRdAck, StRdUsedw, StRdW0, StRdW1, StDecode, StErr, StWait
  } state_e;

  state_e          state_q, state_d;
  logic            gap_q, gap_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [29:0]     w0_q, w0_d;   // word 0 minus the two unused low bits of b3
  logic [19:0]     w1_q, w1_d;   // {b4, b5[3:0], b6}

  logic [11:0] bx_q, by_q, bz_q, temp_q;
  logic [1:0]  frame_cnt_q;
  logic        sample_valid_q, stale_q, have_q;
  logic [15:0] sample_count_q;

  logic [2:0]  acc_addr;
  logic [31:0] acc_data;
  state_e      acc_next;
  logic        acc_wr, acc_rd;

  // Per-state bus access: register address, write data and follow-on state.
  always_comb begin
    acc_addr = 3'd0;
    acc_data = 32'd0;
    acc_next = state_q;
    acc_wr   = 1'b0;
    acc_rd   = 1'b0;
    unique case (state_q)
      StWrAddr:  begin acc_wr = 1'b1; acc_addr = 3'd0; acc_data = {25'd0, slave_addr};
                       acc_next = StWrRw; end
      StWrRw:    begin acc_wr = 1'b1; acc_addr = 3'd2; acc_data = 32'd1; acc_next = StWrNb; end
      StWrNb:    begin acc_wr = 1'b1; acc_addr = 3'd4; acc_data = 32'(NUM_BYTES);
                       acc_next = StWrRo; end
      StWrRo:    begin acc_wr = 1'b1; acc_addr = 3'd6; acc_data = 32'd1; acc_next = StWrEna; end
      StWrEna:   begin acc_wr = 1'b1; acc_addr = 3'd3; acc_data = 32'd1; acc_next = StRdAck; end
      StRdAck:   begin acc_rd = 1'b1; acc_addr = 3'd5; acc_next = StRdUsedw; end
      StRdUsedw: begin acc_rd = 1'b1; acc_addr = 3'd6; acc_next = StRdW0; end
      StRdW0:    begin acc_rd = 1'b1; acc_addr = 3'd1; acc_next = StRdW1; end
      StRdW1:    begin acc_rd = 1'b1; acc_addr = 3'd1; acc_next = StDecode; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gap_d   = 1'b0;
    cnt_d   = cnt_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    avm.avm_address   = 3'd0;
    avm.avm_write     = 1'b0;
    avm.avm_writedata = 32'd0;
    avm.avm_read      = 1'b0;
    unique case (state_q)
      StIdle: if (enable) state_d = StWrAddr;
      StDecode, StErr: begin
        state_d = StWait;
        cnt_d   = CntLoad;
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StWrAddr;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // gap_q marks the mandatory idle cycle after each completed access
        if (!gap_q) begin
          avm.avm_write     = acc_wr;
          avm.avm_read      = acc_rd;
          avm.avm_address   = acc_addr;
          avm.avm_writedata = acc_data;
          if (!avm.avm_waitrequest) begin
            gap_d   = 1'b1;
            state_d = acc_next;
            unique case (state_q)
              StRdAck:   if (avm.avm_readdata != 32'd0) state_d = StErr;
              StRdUsedw: if (avm.avm_readdata < 32'd2) state_d = StErr;
              StRdW0:    w0_d = avm.avm_readdata[31:2];
              StRdW1:    w1_d = {avm.avm_readdata[31:24], avm.avm_readdata[19:8]};
              default:   ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gap_q   <= 1'b0;
      cnt_q   <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bx_q           <= '0;
      by_q           <= '0;
      bz_q           <= '0;
      temp_q         <= '0;
      frame_cnt_q    <= '0;
      sample_valid_q <= 1'b0;
      stale_q        <= 1'b0;
      have_q         <= 1'b0;
      sample_count_q <= '0;
    end else begin
      sample_valid_q <= 1'b0;
      if (state_q == StDecode) begin
        bx_q           <= {w0_q[29:22], w1_q[19:16]};
        by_q           <= {w0_q[21:14], w1_q[15:12]};
        bz_q           <= {w0_q[13:6], w1_q[11:8]};
        temp_q         <= {w0_q[5:2], w1_q[7:0]};
        frame_cnt_q    <= w0_q[1:0];
        // first sample after reset has nothing to compare against
        stale_q        <= have_q && (w0_q[1:0] == frame_cnt_q);
        have_q         <= 1'b1;
        sample_valid_q <= 1'b1;
        sample_count_q <= sample_count_q + 16'd1;
      end
    end
  end

  assign bx           = bx_q;
  assign by           = by_q;
  assign bz           = bz_q;
  assign temp         = temp_q;
  assign frame_cnt    = frame_cnt_q;
  assign sample_valid = sample_valid_q;
  assign stale        = stale_q;
  assign sample_count = sample_count_q;
  assign error        = (state_q == StErr);

endmodule

// File: tb/tb_tlv493d_poller.sv
// Bench for tlv493d_poller: behavioural I2C-bridge slave, access/sample scoreboards.
module tb_tlv493d_poller;
  localparam int POLL_TICKS = 20;

  typedef struct packed {logic wr; logic [2:0] addr; logic [31:0] data;} acc_t;
  typedef struct packed {
    logic [11:0] bx, by, bz, temp; logic [1:0] frm; logic stale; logic [15:0] cnt;
  } samp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [6:0] slave_addr = 7'h5E;
  logic [11:0] bx, by, bz, temp;
  logic [1:0] frame_cnt;
  logic sample_valid, stale, error;
  logic [15:0] sample_count;

  tlv493d_poller_if bus ();

  tlv493d_poller #(.CLOCK_SPEED_HZ(1000), .POLL_HZ(50), .NUM_BYTES(7)) dut (
    .clock(clock), .reset(reset), .enable(enable), .slave_addr(slave_addr), .avm(bus),
    .bx(bx), .by(by), .bz(bz), .temp(temp), .frame_cnt(frame_cnt),
    .sample_valid(sample_valid), .stale(stale), .error(error), .sample_count(sample_count)
  );

  always #5 clock = ~clock;

  // Bridge model controls, written only by the stimulus process
  int          stall_ena = 3;
  int          stall_rd = 0;
  logic [31:0] ack_val = 32'd0;
  logic [31:0] usedw_val = 32'd2;
  logic [31:0] fifo_mem [64];
  int          fifo_wr = 0;

  logic [5:0]  fifo_rd;
  int          wait_cnt;
  int          stall_target;
  logic        req;
  logic [31:0] rd_val;

  assign req = bus.avm_read | bus.avm_write;

  always_comb begin
    stall_target = 0;
    if (bus.avm_write && bus.avm_address == 3'd3) stall_target = stall_ena;
    else if (bus.avm_read) stall_target = stall_rd;
  end

  always_comb begin
    rd_val = 32'd0;
    case (bus.avm_address)
      3'd5: rd_val = ack_val;
      3'd6: rd_val = usedw_val;
      3'd1: rd_val = fifo_mem[fifo_rd];
      default: ;
    endcase
  end

  assign bus.avm_readdata    = rd_val;
  assign bus.avm_waitrequest = req && (wait_cnt < stall_target);

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= 0;
    end else if (req && bus.avm_waitrequest) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (req && bus.avm_read && bus.avm_address == 3'd1) fifo_rd <= fifo_rd + 6'd1;
    end
  end

  initial fifo_rd = 6'd0;

  // Monitor: logs completed accesses, samples, errors and protocol violations
  acc_t  acc_log [$];
  int    acc_cyc [$];
  samp_t samp_log [$];
  int    err_log [$];
  int    cyc = 0;
  int    unstable = 0, both_hi = 0, gap_viol = 0, err_long = 0;
  logic  prev_stalled = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  logic [36:0] prev_req = '0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      prev_stalled = 1'b0;
      prev_done    = 1'b0;
      prev_err     = 1'b0;
    end else begin
      if (bus.avm_read && bus.avm_write) both_hi = both_hi + 1;
      if (req && prev_done) gap_viol = gap_viol + 1;
      if (req && prev_stalled &&
          {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata} != prev_req)
        unstable = unstable + 1;
      prev_stalled = req && bus.avm_waitrequest;
      prev_req     = {bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata};
      prev_done    = req && !bus.avm_waitrequest;
      if (req && !bus.avm_waitrequest) begin
        acc_log.push_back({bus.avm_write, bus.avm_address,
                           bus.avm_write ? bus.avm_writedata : 32'd0});
        acc_cyc.push_back(cyc);
      end
      if (sample_valid)
        samp_log.push_back({bx, by, bz, temp, frame_cnt, stale, sample_count});
      if (error) begin
        err_log.push_back(cyc);
        if (prev_err) err_long = err_long + 1;
      end
      prev_err = error;
    end
  end

  // Scoreboard and reference model of the decoded sample stream
  acc_t  exp_acc [$];
  samp_t exp_samp [$];
  logic  m_have = 1'b0;
  logic [1:0] m_frm = 2'd0;
  logic [15:0] m_cnt = 16'd0;
  samp_t m_last = '0;
  int n_cmp = 0, n_fail = 0;

  task automatic model_reset();
    m_have = 1'b0; m_frm = 2'd0; m_cnt = 16'd0; m_last = '0;
  endtask

  task automatic push_writes(input int n);
    acc_t w [5];
    w[0] = {1'b1, 3'd0, {25'd0, slave_addr}};
    w[1] = {1'b1, 3'd2, 32'd1};
    w[2] = {1'b1, 3'd4, 32'd7};
    w[3] = {1'b1, 3'd6, 32'd1};
    w[4] = {1'b1, 3'd3, 32'd1};
    for (int i = 0; i < n; i++) exp_acc.push_back(w[i]);
  endtask

  task automatic expect_frame(input logic [31:0] w0, input logic [31:0] w1);
    samp_t s;
    fifo_mem[fifo_wr % 64] = w0;
    fifo_mem[(fifo_wr + 1) % 64] = w1;
    fifo_wr = fifo_wr + 2;
    push_writes(5);
    exp_acc.push_back({1'b0, 3'd5, 32'd0});
    exp_acc.push_back({1'b0, 3'd6, 32'd0});
    exp_acc.push_back({1'b0, 3'd1, 32'd0});
    exp_acc.push_back({1'b0, 3'd1, 32'd0});
    s.bx = {w0[31:24], w1[31:28]};
    s.by = {w0[23:16], w1[27:24]};
    s.bz = {w0[15:8], w1[19:16]};
    s.temp = {w0[7:4], w1[15:8]};
    s.frm = w0[3:2];
    s.stale = m_have && (w0[3:2] == m_frm);
    m_cnt = m_cnt + 16'd1;
    s.cnt = m_cnt;
    m_have = 1'b1;
    m_frm = w0[3:2];
    m_last = s;
    exp_samp.push_back(s);
  endtask

  task automatic kick();
    @(negedge clock); enable = 1'b1;
    @(negedge clock); enable = 1'b0;
  endtask

  task automatic wait_samp(input int n, input int bound);
    for (int i = 0; i < bound && samp_log.size() < n; i++) @(negedge clock);
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({bx, by, bz, temp, frame_cnt, sample_valid, stale, error, sample_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, need all 0");
    end
    n_cmp++;
    if ({bus.avm_read, bus.avm_write} !== 2'b00) begin
      n_fail++; $display("FAIL reset_bus: rd/wr=%b need 00", {bus.avm_read, bus.avm_write});
    end
    @(negedge clock); reset = 1'b0;
    repeat (5) @(negedge clock);
    n_cmp++;
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL idle_no_traffic: req=%b need 0", req);
    end
  endtask

  task automatic test_basic_frame();
    acc_t a, e; samp_t s, es;
    expect_frame(32'h12345678, 32'h9ABC0000);
    kick();
    wait_samp(1, 300);
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL basic_access: got %h need %h", a, e); end
    end
    n_cmp++;
    if (acc_log.size() != 0) begin
      n_fail++; $display("FAIL basic_extra_access: got %0d extra need 0", acc_log.size());
    end
    es = exp_samp.pop_front();
    s = (samp_log.size() > 0) ? samp_log.pop_front() : 'x;
    n_cmp++;
    if (s !== es) begin n_fail++; $display("FAIL basic_sample: got %h need %h", s, es); end
    n_cmp++;
    if (samp_log.size() != 0) begin
      n_fail++; $display("FAIL basic_valid_once: got %0d extra pulses need 0", samp_log.size());
    end
    n_cmp++;
    if ({bx, by, bz, temp, frame_cnt} !== {12'h129, 12'h34A, 12'h56C, 12'h700, 2'd2}) begin
      n_fail++;
      $display("FAIL basic_fields: got %h %h %h %h %0d need 129 34a 56c 700 2",
               bx, by, bz, temp, frame_cnt);
    end
  endtask

  task automatic test_ack_error();
    acc_t a, e; int meas;
    ack_val = 32'd1;
    for (int k = 0; k < 2; k++) begin
      push_writes(5);
      exp_acc.push_back({1'b0, 3'd5, 32'd0});
    end
    @(negedge clock); enable = 1'b1;
    for (int i = 0; i < 300 && err_log.size() < 2; i++) @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    ack_val = 32'd0;
    meas = (acc_cyc.size() > 6 && err_log.size() > 0) ? acc_cyc[6] - err_log[0] : -1;
    n_cmp++;
    if (meas != POLL_TICKS + 1) begin
      n_fail++; $display("FAIL err_retry_delay: got %0d cycles need %0d", meas, POLL_TICKS + 1);
    end
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL err_access: got %h need %h", a, e); end
    end
    n_cmp++;
    if (acc_log.size() != 0) begin
      n_fail++; $display("FAIL err_no_fifo_read: got %0d extra accesses need 0", acc_log.size());
    end
    n_cmp++;
    if (err_log.size() != 2 || err_long != 0) begin
      n_fail++; $display("FAIL err_pulses: got %0d (long %0d) need 2 (0)", err_log.size(), err_long);
    end
    n_cmp++;
    if ({bx, by, bz, temp, frame_cnt, sample_count} !==
        {m_last.bx, m_last.by, m_last.bz, m_last.temp, m_last.frm, m_cnt}) begin
      n_fail++; $display("FAIL err_outputs_kept: got %h need %h",
                         {bx, by, bz, temp, frame_cnt, sample_count},
                         {m_last.bx, m_last.by, m_last.bz, m_last.temp, m_last.frm, m_cnt});
    end
    n_cmp++;
    if (samp_log.size() != 0) begin
      n_fail++; $display("FAIL err_no_sample: got %0d samples need 0", samp_log.size());
    end
    err_log.delete();
  endtask

  task automatic test_long_stall();
    acc_t a, e; samp_t s, es;
    stall_ena = 40; stall_rd = 40;
    expect_frame(32'h12345678, 32'h9ABC0000);
    kick();
    wait_samp(1, 800);
    stall_ena = 3; stall_rd = 0;
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL stall_access: got %h need %h", a, e); end
    end
    es = exp_samp.pop_front();
    s = (samp_log.size() > 0) ? samp_log.pop_front() : 'x;
    n_cmp++;
    if (s !== es) begin n_fail++; $display("FAIL stall_sample: got %h need %h", s, es); end
    n_cmp++;
    if (unstable != 0) begin
      n_fail++; $display("FAIL stall_req_stable: got %0d changes need 0", unstable);
    end
    n_cmp++;
    if (both_hi != 0 || gap_viol != 0) begin
      n_fail++; $display("FAIL bus_protocol: got both_hi=%0d gap_viol=%0d need 0/0",
                         both_hi, gap_viol);
    end
  endtask

  task automatic test_stale();
    acc_t a, e; samp_t s, es;
    logic [31:0] w0s [3];
    logic [31:0] w1s [3];
    w0s[0] = 32'h11223304; w1s[0] = 32'h44556600;
    w0s[1] = 32'hAABBCC05; w1s[1] = 32'hDDEEFF00;
    w0s[2] = 32'h0102030C; w1s[2] = 32'hF0E1D200;
    @(negedge clock); reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clock); reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_frame(w0s[k], w1s[k]);
      kick();
      wait_samp(k + 1, 300);
    end
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL stale_access: got %h need %h", a, e); end
    end
    for (int k = 0; k < 3; k++) begin
      es = exp_samp.pop_front();
      s = (samp_log.size() > 0) ? samp_log.pop_front() : 'x;
      n_cmp++;
      if (s !== es) begin n_fail++; $display("FAIL stale_sample%0d: got %h need %h", k, s, es); end
    end
  endtask

  task automatic test_enable_drop();
    acc_t a, e; samp_t s, es; int req_seen;
    stall_rd = 5;
    expect_frame(32'h7F00800C, 32'h0F5A3C00);
    @(negedge clock); enable = 1'b1;
    for (int i = 0; i < 300 && !(bus.avm_read && bus.avm_address == 3'd1); i++)
      @(negedge clock);
    enable = 1'b0;
    wait_samp(1, 300);
    stall_rd = 0;
    req_seen = 0;
    for (int i = 0; i < 2 * POLL_TICKS; i++) begin
      @(negedge clock);
      if (req) req_seen++;
    end
    n_cmp++;
    if (req_seen != 0) begin
      n_fail++; $display("FAIL drop_no_traffic: got %0d request cycles need 0", req_seen);
    end
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL drop_access: got %h need %h", a, e); end
    end
    es = exp_samp.pop_front();
    s = (samp_log.size() > 0) ? samp_log.pop_front() : 'x;
    n_cmp++;
    if (s !== es) begin n_fail++; $display("FAIL drop_sample: got %h need %h", s, es); end
  endtask

  task automatic test_reset_mid_access();
    acc_t a, e; samp_t s, es;
    stall_ena = 40;
    push_writes(4);
    @(negedge clock); enable = 1'b1;
    for (int i = 0; i < 200 && !(bus.avm_write && bus.avm_address == 3'd3); i++)
      @(negedge clock);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.avm_read, bus.avm_write} !== 2'b00) begin
      n_fail++; $display("FAIL rst_bus_drop: rd/wr=%b need 00", {bus.avm_read, bus.avm_write});
    end
    n_cmp++;
    if ({bx, by, bz, temp, frame_cnt, sample_valid, stale, error, sample_count} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: got nonzero outputs need all 0");
    end
    model_reset();
    stall_ena = 3;
    expect_frame(32'h12345678, 32'h9ABC0000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); enable = 1'b0;
    wait_samp(1, 300);
    while (exp_acc.size() > 0) begin
      e = exp_acc.pop_front();
      a = (acc_log.size() > 0) ? acc_log.pop_front() : 'x;
      if (acc_cyc.size() > 0) void'(acc_cyc.pop_front());
      n_cmp++;
      if (a !== e) begin n_fail++; $display("FAIL rst_access: got %h need %h", a, e); end
    end
    es = exp_samp.pop_front();
    s = (samp_log.size() > 0) ? samp_log.pop_front() : 'x;
    n_cmp++;
    if (s !== es) begin n_fail++; $display("FAIL rst_restart_sample: got %h need %h", s, es); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_ack_error();
    test_long_stall();
    test_stale();
    test_enable_drop();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
